demux1_8_reg: RTL and testbench

//  Registered 1-to-8 demultiplexer: the distribution-side counterpart of mux8_1.

---
 rtl/demux_pkg.sv | 9 +
 rtl/decoder3_8.sv | 18 +
 rtl/demux1_8_reg.sv | 59 +++++
 tb/tb_demux1_8_reg.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared lane count, select width and lane mask type for the demux slice.
package demux_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef logic [LANES-1:0] lane_mask_t;

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder with enable; all-zero mask when disabled.
module decoder3_8
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output lane_mask_t       mask
);

    // One bit set at the selected lane when enabled.
    always_comb begin
        mask = '0;
        if (en) begin
            mask[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1_8_reg.sv
// Registered 1-to-8 demultiplexer with per-lane one-entry buffers and
// valid/ready handshake on both sides. Broadcast writes every lane, but only
// when all eight lanes can take the word in the same cycle.
module demux1_8_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_bcast,
    input  logic [SEL_W-1:0]             in_sel,
    input  logic [WIDTH-1:0]             in_data,
    output logic [LANES-1:0]             out_valid,
    input  logic [LANES-1:0]             out_ready,
    output logic [LANES-1:0][WIDTH-1:0]  out_data
);

    lane_mask_t can_acc;
    lane_mask_t sel_mask;
    lane_mask_t wr_mask;
    logic       accept;

    // A lane can take a word when empty or when its current word leaves this cycle.
    always_comb begin
        can_acc  = ~out_valid | out_ready;
        in_ready = in_bcast ? (&can_acc) : can_acc[in_sel];
        accept   = in_valid & in_ready;
    end

    decoder3_8 u_dec (
        .sel  (in_sel),
        .en   (accept),
        .mask (sel_mask)
    );

    // Broadcast writes all lanes together; otherwise only the decoded lane.
    always_comb begin
        wr_mask = in_bcast ? {LANES{accept}} : sel_mask;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Lane buffer: write wins over drain so a same-cycle drain+fill leaves no bubble.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_valid[i] <= 1'b0;
                out_data[i]  <= '0;
            end else if (wr_mask[i]) begin
                out_valid[i] <= 1'b1;
                out_data[i]  <= in_data;
            end else if (out_valid[i] && out_ready[i]) begin
                out_valid[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux1_8_reg.sv
// Self-checking bench for demux1_8_reg: directed scenarios plus random
// traffic scored against per-lane queues of expected words.
module tb_demux1_8_reg;

    localparam int W = 64;

    logic                 clk;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_bcast;
    logic [2:0]           in_sel;
    logic [W-1:0]         in_data;
    logic [7:0]           out_valid;
    logic [7:0]           out_ready;
    logic [7:0][W-1:0]    out_data;

    int errors = 0;
    int checks = 0;

    // Reference: each lane is a queue of words the consumer has yet to receive.
    logic [W-1:0] sb [8][$];

    demux1_8_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcast  (in_bcast),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic b, input logic [2:0] s,
                         input logic [W-1:0] d, input logic [7:0] r);
        in_valid  = v;
        in_bcast  = b;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        reset_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL reset_valid: got %h want 00", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_valid: got %h want 00", out_valid);
        end
    endtask

    task automatic test_single_write();
        drive(1'b1, 1'b0, 3'd5, 64'hDEAD, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid !== 8'h20 || out_data[5] !== 64'hDEAD) begin
                errors++;
                $display("FAIL single_hold: valid=%h data5=%h want 20/dead", out_valid, out_data[5]);
            end
            tick();
        end
        out_ready = 8'h20;
        tick();
        out_ready = 8'h00;
        checks++;
        if (out_valid !== 8'h00 || out_data[5] !== 64'hDEAD) begin
            errors++;
            $display("FAIL single_drain: valid=%h data5=%h want 00/dead", out_valid, out_data[5]);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 3'd2, 64'h1234, 8'h00);
        tick();
        drive(1'b1, 1'b0, 3'd2, 64'hBEEF, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_full: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 8'h04 || out_data[2] !== 64'h1234) begin
            errors++;
            $display("FAIL bp_lane2_kept: valid=%h data2=%h want 04/1234", out_valid, out_data[2]);
        end
        drive(1'b1, 1'b0, 3'd3, 64'h3333, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_other: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        checks++;
        if (out_valid !== 8'h0C || out_data[3] !== 64'h3333 || out_data[2] !== 64'h1234) begin
            errors++;
            $display("FAIL bp_other_lane: valid=%h d2=%h d3=%h want 0c/1234/3333",
                     out_valid, out_data[2], out_data[3]);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
    endtask

    task automatic test_drain_fill();
        drive(1'b1, 1'b0, 3'd2, 64'h11, 8'h00);
        tick();
        drive(1'b1, 1'b0, 3'd2, 64'h22, 8'h04);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL df_in_ready: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        checks++;
        if (out_valid !== 8'h04 || out_data[2] !== 64'h22) begin
            errors++;
            $display("FAIL df_replace: valid=%h data2=%h want 04/22", out_valid, out_data[2]);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
    endtask

    task automatic test_broadcast();
        drive(1'b1, 1'b1, 3'd6, 64'h1, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bc_in_ready_empty: got %b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 8'hFF) begin
            errors++;
            $display("FAIL bc_valid: got %h want ff", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data[i] !== 64'h1) begin
                errors++;
                $display("FAIL bc_data lane %0d: got %h want 1", i, out_data[i]);
            end
        end
        // Every lane full and stalled: broadcast refused, nothing moves.
        drive(1'b1, 1'b1, 3'd0, 64'h2, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bc_in_ready_stalled: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 8'hFF || out_data[0] !== 64'h1 || out_data[7] !== 64'h1) begin
            errors++;
            $display("FAIL bc_no_change: valid=%h d0=%h d7=%h want ff/1/1",
                     out_valid, out_data[0], out_data[7]);
        end
        // Only lane 7 stalled: still refused; the other lanes just drain.
        drive(1'b1, 1'b1, 3'd0, 64'h2, 8'h7F);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bc_in_ready_lane7: got %b want 0", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        checks++;
        if (out_valid !== 8'h80 || out_data[7] !== 64'h1 || out_data[0] !== 64'h1) begin
            errors++;
            $display("FAIL bc_all_or_nothing: valid=%h d0=%h d7=%h want 80/1/1",
                     out_valid, out_data[0], out_data[7]);
        end
        // Non-broadcast writes to other lanes proceed while lane 7 stalls.
        drive(1'b1, 1'b0, 3'd1, 64'h55, 8'h00);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bc_indep_lane1: got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, '0, 8'hFF);
        tick();
        out_ready = 8'h00;
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL bc_final_drain: got %h want 00", out_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] can;
        logic       exp_ready;
        logic       acc;
        int         delivered;
        delivered = 0;
        for (int i = 0; i < 8; i++) sb[i].delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [7:0] r;
            if (cyc < 200)      r = 8'($urandom);
            else if (cyc < 400) r = 8'($urandom) & 8'($urandom);
            else                r = 8'($urandom) | 8'($urandom);
            drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  3'($urandom), {$urandom, $urandom}, r);
            #1;
            for (int i = 0; i < 8; i++) begin
                can[i] = (sb[i].size() == 0) || out_ready[i];
                checks++;
                if (out_valid[i] !== (sb[i].size() != 0)) begin
                    errors++;
                    $display("FAIL rand_valid cyc %0d lane %0d: got %b want %b",
                             cyc, i, out_valid[i], sb[i].size() != 0);
                end else if (sb[i].size() != 0) begin
                    checks++;
                    if (out_data[i] !== sb[i][0]) begin
                        errors++;
                        $display("FAIL rand_data cyc %0d lane %0d: got %h want %h",
                                 cyc, i, out_data[i], sb[i][0]);
                    end
                end
            end
            exp_ready = in_bcast ? (can == 8'hFF) : can[in_sel];
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ready);
            end
            acc = in_valid && exp_ready;
            tick();
            for (int i = 0; i < 8; i++) begin
                if (r[i] && sb[i].size() != 0) begin
                    void'(sb[i].pop_front());
                    delivered++;
                end
            end
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    if (in_bcast || in_sel == 3'(i)) sb[i].push_back(in_data);
                end
            end
        end
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL rand_throughput: delivered %0d want >= 100", delivered);
        end
    endtask

    task automatic test_reset_mid_traffic();
        drive(1'b1, 1'b1, 3'd0, 64'hA5A5, 8'h00);
        tick();
        drive(1'b1, 1'b0, 3'd4, 64'h7777, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 8'h00 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%h data=%h want 00/0", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 8'h00 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_held: valid=%h want 00", out_valid);
        end
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_release: valid=%h want 00", out_valid);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0, '0, 8'h00);
        #2;
        test_reset();
        test_single_write();
        test_backpressure();
        test_drain_fill();
        test_broadcast();
        test_random();
        test_reset_mid_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
